// File: rtl/spi_slave_trx.sv
// SPI mode-0 slave byte transceiver: synchronises sck/mosi/ss into clk, presents
// each received byte with a one-cycle pop strobe and serialises decoder responses.
module spi_slave_trx #(
  parameter logic [7:0] TX_IDLE = 8'hff
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       ss,
  output logic       miso,
  output logic       rst_o,
  output logic [7:0] data_o,
  output logic       ack_pop_o,
  input  logic [7:0] data_i,
  input  logic       ack_i
);

  logic       sck_s1, sck_s2, sck_s3;
  logic       mosi_s1, mosi_s2;
  logic       ss_s1, ss_s2;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] pending_buf;
  logic       pending_valid;

  logic rise, fall, boundary_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      ss_s1   <= ss;
      ss_s2   <= ss_s1;
    end
  end

  always_comb begin
    rise          = sck_s2 & ~sck_s3;
    fall          = ~sck_s2 & sck_s3;
    boundary_load = fall && (bit_cnt == 3'd0);
  end

  assign rst_o = ss_s2;
  assign miso  = tx_shift[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= TX_IDLE;
      pending_buf   <= '0;
      pending_valid <= 1'b0;
      data_o        <= '0;
      ack_pop_o     <= 1'b0;
    end else begin
      ack_pop_o <= 1'b0;
      if (ss_s2) begin
        bit_cnt       <= '0;
        tx_shift      <= TX_IDLE;
        pending_valid <= 1'b0;
      end else begin
        if (rise) begin
          rx_shift <= {rx_shift[6:0], mosi_s2};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            data_o    <= {rx_shift[6:0], mosi_s2};
            ack_pop_o <= 1'b1;
          end
        end
        // A response arriving in the load cycle goes straight to the shifter
        if (boundary_load) begin
          if (ack_i)              tx_shift <= data_i;
          else if (pending_valid) tx_shift <= pending_buf;
          else                    tx_shift <= TX_IDLE;
          pending_valid <= 1'b0;
        end else begin
          if (fall) tx_shift <= {tx_shift[6:0], 1'b1};
          if (ack_i) begin
            pending_buf   <= data_i;
            pending_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_trx.sv
// Directed bench for spi_slave_trx: a cycle-stepped SPI master with hand-computed
// expected receive bytes, pop timing and miso responses.
module tb_spi_slave_trx;

  localparam int H  = 4;              // sck half period in clk cycles
  localparam int C8 = 7 * 2 * H + H;  // cycle index of the 8th sck rise

  logic       clk = 1'b0;
  logic       rst;
  logic       sck, mosi, ss;
  logic       miso, rst_o, ack_pop_o, ack_i;
  logic [7:0] data_o, data_i, rx;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int pops_base;

  spi_slave_trx #(.TX_IDLE(8'hff)) dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ss(ss),
    .miso(miso), .rst_o(rst_o), .data_o(data_o), .ack_pop_o(ack_pop_o),
    .data_i(data_i), .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ack_pop_o) pops <= pops + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sck = 1'b0; ack_i = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Shifts nbits of tx MSB first; ack_a/ack_b are cycle indices for ack_i pulses (-1 = none).
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input logic [7:0] exp_miso,
                          input int ack_a, input logic [7:0] dat_a,
                          input int ack_b, input logic [7:0] dat_b);
    logic [7:0] got;
    got = '0;
    for (int c = 0; c < nbits * 2 * H; c++) begin
      int b, ph;
      b  = c / (2 * H);
      ph = c % (2 * H);
      @(negedge clk);
      if (ph == H) got = {got[6:0], miso};
      sck    = (ph >= H);
      mosi   = tx[7-b];
      ack_i  = (c == ack_a) || (c == ack_b);
      data_i = (c == ack_b) ? dat_b : dat_a;
      @(posedge clk); #1;
      if (nbits == 8) begin
        if (c == C8 + 1) check("pop_early", ack_pop_o, 1'b0);
        if (c == C8 + 2) begin
          check("pop", ack_pop_o, 1'b1);
          check("data_o", data_o, tx);
        end
        if (c == C8 + 3) check("pop_width", ack_pop_o, 1'b0);
      end else begin
        check("pop_partial", ack_pop_o, 1'b0);
      end
    end
    @(negedge clk);
    ack_i = 1'b0;
    if (nbits == 8) check("miso_byte", got, exp_miso);
  endtask

  initial begin
    rst = 1'b1; ss = 1'b0; sck = 1'b0; mosi = 1'b0; ack_i = 1'b0; data_i = '0;

    // reset with the slave selected and sck toggling
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sck = i[1];
      @(posedge clk); #1;
      if (i == 5 || i == 11) begin
        check("rst_data_o", data_o, 8'h00);
        check("rst_pop", ack_pop_o, 1'b0);
        check("rst_rst_o", rst_o, 1'b1);
        check("rst_miso", miso, 1'b1);
      end
    end
    @(negedge clk);
    sck = 1'b0; rst = 1'b0;
    idle(8);
    check("sel_rst_o", rst_o, 1'b0);
    check("idle_pop_cnt", pops, 0);

    // first byte of a session returns idle
    spi_byte(8'hA5, 8, 8'hff, -1, 8'h00, -1, 8'h00);
    check("a5_pop_cnt", pops, 1);

    // echo: response handed over two cycles after the pop goes out in the next byte
    spi_byte(8'h3C, 8, 8'hff, -1, 8'h00, -1, 8'h00);
    spi_byte(8'hC3, 8, 8'h5A,  0, 8'h5A, -1, 8'h00);
    spi_byte(8'h0F, 8, 8'hff, -1, 8'h00, -1, 8'h00);

    // two responses before the boundary: the latest wins
    spi_byte(8'h44, 8, 8'hff, 10, 8'h11, 30, 8'h22);
    spi_byte(8'h55, 8, 8'h22, -1, 8'h00, -1, 8'h00);
    // response in the boundary load cycle bypasses the buffer
    spi_byte(8'h66, 8, 8'h33,  2, 8'h33, -1, 8'h00);
    spi_byte(8'h77, 8, 8'hff, -1, 8'h00, -1, 8'h00);

    // deselect mid-byte with a stale pending response
    spi_byte(8'hB4, 5, 8'hff, 5, 8'h99, -1, 8'h00);
    pops_base = pops;
    @(negedge clk);
    sck = 1'b0; ss = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("desel_rst_o", rst_o, 1'b1);
    idle(8);
    check("desel_pop_cnt", pops, pops_base);
    check("desel_data_hold", data_o, 8'h77);
    check("desel_miso", miso, 1'b1);
    @(negedge clk);
    ss = 1'b0;
    idle(6);
    check("resel_rst_o", rst_o, 1'b0);
    spi_byte(8'h81, 8, 8'hff, -1, 8'h00, -1, 8'h00);
    check("resel_pop_cnt", pops, pops_base + 1);

    // long session: counter wraps cleanly across 256 bytes
    pops_base = pops;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = i[7:0];
      spi_byte(v, 8, 8'hff, -1, 8'h00, -1, 8'h00);
    end
    idle(8);
    check("burst_pop_cnt", pops, pops_base + 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
